// File: rtl/seq_mult4_pkg.sv
// Shared definitions for the sequential 4x4 shift-and-add multiplier.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_mult4_pkg;

    localparam int MULT_W    = 4;
    localparam int MULT_ITER = 4;
    localparam int PROD_W    = 2 * MULT_W;
    localparam int CNT_W     = 2;

    // Counter value on which the final iteration runs.
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MULT_ITER - 1);

    // 2'b11 is unused; the FSM recovers from it to S_IDLE on the next edge.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/seq_mult4_if.sv
// Start/busy/done handshake and operand/result bus of the multiplier.
// Latency: n/a (wiring only).
// Backpressure: none; start is simply ignored while busy.
interface seq_mult4_if
    import seq_mult4_pkg::*;
();
    logic              start;
    logic [MULT_W-1:0] a;
    logic [MULT_W-1:0] b;
    logic              busy;
    logic              done;
    logic [PROD_W-1:0] product;

    // Control logic side: requests multiplies and watches the result.
    modport master (output start, a, b, input busy, done, product);
    // Multiplier side.
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/fulladder.sv
// 4-bit adder with carry in and carry out, consumed combinationally each cycle.
// Latency: 0 cycles (purely combinational).
// Backpressure: n/a.
module fulladder (
    output logic [3:0] sum,
    output logic       carry_out,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0
);

    // Full 5-bit result so the carry is never lost.
    always_comb begin
        {carry_out, sum} = 5'(a) + 5'(b) + 5'(c0);
    end

endmodule

// File: rtl/seq_mult4_dp.sv
// Multiplier datapath: M/A/Q registers, addend mux, adder and right shift.
// Latency: one add/shift iteration per cycle while run_i is high.
// Backpressure: none; the FSM in the top level sequences load_i/run_i.
module seq_mult4_dp
    import seq_mult4_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              run_i,
    input  logic [MULT_W-1:0] a_i,
    input  logic [MULT_W-1:0] b_i,
    output logic [PROD_W-1:0] prod_nxt_o
);

    logic [MULT_W-1:0] m_q, m_d;
    logic [MULT_W-1:0] acc_q, acc_d;
    logic [MULT_W-1:0] mq_q, mq_d;
    logic [MULT_W-1:0] addend;
    logic [MULT_W-1:0] sum;
    logic              carry;

    // Add the multiplicand only when the current multiplier LSB is set.
    always_comb begin
        addend = mq_q[0] ? m_q : '0;
    end

    fulladder u_add (
        .sum       (sum),
        .carry_out (carry),
        .a         (acc_q),
        .b         (addend),
        .c0        (1'b0)
    );

    // Load operands on accept; otherwise shift {carry, sum, Q} right by one.
    always_comb begin
        m_d   = m_q;
        acc_d = acc_q;
        mq_d  = mq_q;
        if (load_i) begin
            m_d   = a_i;
            acc_d = '0;
            mq_d  = b_i;
        end else if (run_i) begin
            acc_d = {carry, sum[MULT_W-1:1]};
            mq_d  = {sum[0], mq_q[MULT_W-1:1]};
        end
    end

    // The value A:Q takes after this iteration; captured as the product on the last one.
    always_comb begin
        prod_nxt_o = {carry, sum, mq_q[MULT_W-1:1]};
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q   <= '0;
            acc_q <= '0;
            mq_q  <= '0;
        end else begin
            m_q   <= m_d;
            acc_q <= acc_d;
            mq_q  <= mq_d;
        end
    end

endmodule

// File: rtl/seq_mult4.sv
// Sequential 4x4 unsigned multiplier, FSM + counter + registered result flags.
// Latency: 4 cycles from accepted start to done; 5 cycles per op back-to-back.
// Backpressure: start ignored during RUN; accepted in IDLE or in the done cycle.
module seq_mult4
    import seq_mult4_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    seq_mult4_if.slave  bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PROD_W-1:0] product_q, product_d;
    logic              load;
    logic              run;
    logic [PROD_W-1:0] prod_nxt;

    seq_mult4_dp u_dp (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .run_i      (run),
        .a_i        (bus.a),
        .b_i        (bus.b),
        .prod_nxt_o (prod_nxt)
    );

    // Next state, counter and datapath controls; product only moves when entering DONE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        load      = 1'b0;
        run       = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                run = 1'b1;
                if (cnt_q == LAST_ITER) begin
                    product_d = prod_nxt;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state registers; reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Flags decode straight from registered state.
    always_comb begin
        bus.busy    = (state_q == S_RUN);
        bus.done    = (state_q == S_DONE);
        bus.product = product_q;
    end

endmodule

// File: tb/tb_seq_mult4.sv
// Scoreboard bench for seq_mult4: the driver queues expected products and done cycles,
// a monitor checks busy/done/product every cycle against that queue.
module tb_seq_mult4;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    typedef struct {
        logic [7:0] prod;
        int         done_cyc;
    } exp_t;

    exp_t       q[$];
    logic [7:0] hold;

    seq_mult4_if bus ();

    seq_mult4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Caller is positioned at a negedge. Drives start for one cycle; the
    // accepting edge is the next posedge, so done is due 4 edges after it.
    task automatic issue(input logic [3:0] x, input logic [3:0] y, input bit accept);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        if (accept) q.push_back('{prod: 8'(x) * 8'(y), done_cyc: cyc + 5});
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 4'($urandom);
        bus.b     = 4'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: compares DUT flags and product against the queued expectations.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                bit eb, ed;
                eb = (q.size() != 0) && (cyc >= q[0].done_cyc - 4) && (cyc < q[0].done_cyc);
                ed = (q.size() != 0) && (cyc == q[0].done_cyc);
                chk("busy", int'(bus.busy), int'(eb));
                chk("done", int'(bus.done), int'(ed));
                if (bus.done) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_done: product %0d with nothing expected", bus.product);
                    end else begin
                        chk("product", int'(bus.product), int'(q[0].prod));
                        hold = q[0].prod;
                        void'(q.pop_front());
                    end
                end else begin
                    chk("product_hold", int'(bus.product), int'(hold));
                end
                if (q.size() != 0 && cyc > q[0].done_cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missed_done: expected product %0d at cycle %0d", q[0].prod, q[0].done_cyc);
                    void'(q.pop_front());
                end
            end
        end
    end

    // Stimulus.
    initial begin
        int perm[256];
        cyc       = 0;
        checks    = 0;
        errors    = 0;
        hold      = 8'h00;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = 4'd0;
        bus.b     = 4'd0;
        #7;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_product", int'(bus.product), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed products, including the carry-every-iteration case.
        issue(4'd13, 4'd11, 1'b1); drain();
        issue(4'd15, 4'd15, 1'b1); drain();
        issue(4'd0,  4'd9,  1'b1); drain();
        issue(4'd9,  4'd1,  1'b1); drain();

        // Start pulse during RUN must be ignored.
        issue(4'd6, 4'd7, 1'b1);
        @(negedge clk);
        issue(4'd1, 4'd1, 1'b0);
        drain();

        // Reset mid-run discards the partial result at once.
        issue(4'd12, 4'd5, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        hold = 8'h00;
        #1;
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_done", int'(bus.done), 0);
        chk("midrst_product", int'(bus.product), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(4'd3, 4'd3, 1'b1); drain();

        // Back-to-back: second start held during the done cycle.
        issue(4'd2, 4'd3, 1'b1);
        repeat (4) @(negedge clk);
        issue(4'd4, 4'd4, 1'b1);
        drain();

        // All 256 pairs in random order, back-to-back.
        for (int i = 0; i < 256; i++) perm[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(i, 0));
            t = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        for (int i = 0; i < 256; i++) begin
            issue(4'(perm[i] >> 4), 4'(perm[i]), 1'b1);
            repeat (4) @(negedge clk);
        end
        drain();

        // Random operands with random idle gaps (0 = back-to-back).
        for (int i = 0; i < 60; i++) begin
            issue(4'($urandom), 4'($urandom), 1'b1);
            repeat (4 + $urandom_range(3, 0)) @(negedge clk);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

endmodule
